datapath_control_unit: RTL

- Hardwired Moore control sequencer for the Datapath.
- Steps the fetch phase (T0-T2), decodes the opcode field of IR, and drives the execute phase (T3-T7) for the load/store, register ALU and immediate ALU instruction classes.
- Replaces hand-driven bench control signals; every output connects one-to-one to the Datapath port of the same name.

---
 rtl/datapath_control_unit_if.sv | 31 +++
 rtl/datapath_control_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_control_unit_if.sv
// Control bundle between the hardwired sequencer and the Datapath.
// The sequencer is the master: it reads IR and stop, and drives every control strobe.
interface datapath_control_unit_if;
   logic [31:0] ir;
   logic        stop;
   logic        run;
   logic [3:0]  step;
   logic        Gra, Grb, Grc, Rin, R_out, BAout;
   logic        C_out, PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, In_out;
   logic        MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd;
   logic        IncPC, Read, Write;
   logic [4:0]  op_sel;

   modport master (
      input  ir, stop,
      output run, step,
      output Gra, Grb, Grc, Rin, R_out, BAout,
      output C_out, PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, In_out,
      output MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd,
      output IncPC, Read, Write, op_sel
   );

   modport slave (
      output ir, stop,
      input  run, step,
      input  Gra, Grb, Grc, Rin, R_out, BAout,
      input  C_out, PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, In_out,
      input  MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd,
      input  IncPC, Read, Write, op_sel
   );
endinterface

// File: rtl/datapath_control_unit.sv
// Hardwired Moore sequencer: fetch in T0-T2, decode in T3, execute through T7,
// with PAUSE at instruction boundaries on stop and a HALT state left only by clr.
module datapath_control_unit #(
   parameter int         OPC_HI  = 31,
   parameter logic [4:0] ALU_ADD = 5'b00011
) (
   input logic                     clk,
   input logic                     clr,
   datapath_control_unit_if.master bus
);

   typedef enum logic [3:0] {
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_NOP, C_HALT, C_LD, C_LDI, C_ST, C_ALU3, C_IMM
   } class_t;

   typedef struct packed {
      logic       Gra, Grb, Grc, Rin, R_out, BAout;
      logic       C_out, PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, In_out;
      logic       MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd;
      logic       IncPC, Read, Write;
      logic [4:0] op_sel;
      logic       run;
      logic [3:0] step;
   } ctl_t;

   state_t     state_q, state_d;
   class_t     cls_q, dec_cls, cls;
   logic [4:0] op_q, dec_op, op;
   logic [4:0] opc;
   logic       last;
   ctl_t       cw;

   assign opc = bus.ir[OPC_HI -: 5];

   // Immediate forms map onto the ALU code of their register-form counterpart.
   always_comb begin
      // NOTE: defaults first so every path assigns every signal -- no latches.
      dec_cls = C_NOP;
      dec_op  = 5'b00000;
      case (opc)
         5'b00000: dec_cls = C_LD;
         5'b00001: dec_cls = C_LDI;
         5'b00010: dec_cls = C_ST;
         5'b00011,
         5'b00100,
         5'b00101,
         5'b00110: begin
            dec_cls = C_ALU3;
            dec_op  = opc;
         end
         5'b01100: begin
            dec_cls = C_IMM;
            dec_op  = ALU_ADD;
         end
         5'b01101: begin
            dec_cls = C_IMM;
            dec_op  = 5'b00101;
         end
         5'b01110: begin
            dec_cls = C_IMM;
            dec_op  = 5'b00110;
         end
         5'b11011: dec_cls = C_HALT;
         default:  dec_cls = C_NOP;
      endcase
   end

   // IR is only valid from T3 on, so T3 uses the live decode; later steps use the latch.
   assign cls = (state_q == S_T3) ? dec_cls : cls_q;
   assign op  = (state_q == S_T3) ? dec_op  : op_q;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (clr) begin
         state_q <= S_T0;
         cls_q   <= C_NOP;
         op_q    <= 5'b00000;
      end else begin
         state_q <= state_d;
         if (state_q == S_T3) begin
            cls_q <= dec_cls;
            op_q  <= dec_op;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last    = 1'b0;
      case (state_q)
         S_T0: state_d = S_T1;
         S_T1: state_d = S_T2;
         S_T2: state_d = S_T3;
         S_T3: begin
            if (cls == C_HALT)     state_d = S_HALT;
            else if (cls == C_NOP) last    = 1'b1;
            else                   state_d = S_T4;
         end
         S_T4: state_d = S_T5;
         S_T5: begin
            if (cls == C_LD || cls == C_ST) state_d = S_T6;
            else                            last    = 1'b1;
         end
         S_T6:    state_d = S_T7;
         S_T7:    last    = 1'b1;
         S_PAUSE: if (!bus.stop) state_d = S_T0;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_T0;
      endcase
      if (last) state_d = bus.stop ? S_PAUSE : S_T0;
   end

   always_comb begin
      cw      = '0;
      cw.run  = 1'b1;
      cw.step = state_q;
      case (state_q)
         S_T0: begin
            cw.PC_out = 1'b1;
            cw.MAR_rd = 1'b1;
            cw.IncPC  = 1'b1;
            cw.Zlo_rd = 1'b1;
         end
         S_T1: begin
            cw.Zlo_out = 1'b1;
            cw.PC_rd   = 1'b1;
            cw.Read    = 1'b1;
            cw.MDR_rd  = 1'b1;
         end
         S_T2: begin
            cw.MDR_out = 1'b1;
            cw.IR_rd   = 1'b1;
         end
         S_T3: begin
            case (cls)
               C_ALU3, C_IMM: begin
                  cw.Grb   = 1'b1;
                  cw.R_out = 1'b1;
                  cw.Y_rd  = 1'b1;
               end
               C_LD, C_LDI, C_ST: begin
                  cw.Grb   = 1'b1;
                  cw.BAout = 1'b1;
                  cw.Y_rd  = 1'b1;
               end
               default: ;
            endcase
         end
         S_T4: begin
            cw.Zlo_rd = 1'b1;
            if (cls == C_ALU3) begin
               cw.Grc    = 1'b1;
               cw.R_out  = 1'b1;
               cw.op_sel = op;
            end else begin
               cw.C_out  = 1'b1;
               cw.op_sel = (cls == C_IMM) ? op : ALU_ADD;
            end
         end
         S_T5: begin
            cw.Zlo_out = 1'b1;
            if (cls == C_LD || cls == C_ST) begin
               cw.MAR_rd = 1'b1;
            end else begin
               cw.Gra = 1'b1;
               cw.Rin = 1'b1;
            end
         end
         S_T6: begin
            cw.MDR_rd = 1'b1;
            if (cls == C_ST) begin
               cw.Gra   = 1'b1;
               cw.R_out = 1'b1;
            end else begin
               cw.Read = 1'b1;
            end
         end
         S_T7: begin
            if (cls == C_ST) begin
               cw.Write = 1'b1;
            end else begin
               cw.MDR_out = 1'b1;
               cw.Gra     = 1'b1;
               cw.Rin     = 1'b1;
            end
         end
         default: begin
            cw.run  = 1'b0;
            cw.step = 4'hF;
         end
      endcase
      if (clr) cw = '0;
   end

   assign bus.run     = cw.run;
   assign bus.step    = cw.step;
   assign bus.Gra     = cw.Gra;
   assign bus.Grb     = cw.Grb;
   assign bus.Grc     = cw.Grc;
   assign bus.Rin     = cw.Rin;
   assign bus.R_out   = cw.R_out;
   assign bus.BAout   = cw.BAout;
   assign bus.C_out   = cw.C_out;
   assign bus.PC_out  = cw.PC_out;
   assign bus.MDR_out = cw.MDR_out;
   assign bus.Zlo_out = cw.Zlo_out;
   assign bus.Zhi_out = cw.Zhi_out;
   assign bus.HI_out  = cw.HI_out;
   assign bus.LO_out  = cw.LO_out;
   assign bus.In_out  = cw.In_out;
   assign bus.MAR_rd  = cw.MAR_rd;
   assign bus.Zlo_rd  = cw.Zlo_rd;
   assign bus.PC_rd   = cw.PC_rd;
   assign bus.MDR_rd  = cw.MDR_rd;
   assign bus.IR_rd   = cw.IR_rd;
   assign bus.Y_rd    = cw.Y_rd;
   assign bus.IncPC   = cw.IncPC;
   assign bus.Read    = cw.Read;
   assign bus.Write   = cw.Write;
   assign bus.op_sel  = cw.op_sel;

endmodule
